seg7_decimal_display: RTL and testbench

Parametrised binary-to-decimal seven-segment driver: converts an unsigned WIDTH-bit value to DIGITS BCD digits with a sequential double-dabble engine (one bit per clock) and drives DIGITS seven-segment displays. It sits between the core's result/input datapath and the board HEX displays. It replaces the per-digit combinational divide/modulo decode and adds a load/busy/done handshake, overflow indication, leading-zero blanking and a blank control.

---
 rtl/seg7_decimal_display.sv | 147 ++++++++++++++
 tb/tb_seg7_decimal_display.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_decimal_display.sv
// Binary-to-decimal seven-segment driver: sequential double-dabble (one bit per clock)
// with load/busy/done handshake, overflow dashes, leading-zero blanking and blank control.
module seg7_decimal_display #(
   parameter int WIDTH      = 16,
   parameter int DIGITS     = 4,
   parameter int ACTIVE_LOW = 1,
   parameter int LZ_BLANK   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      value,
   input  logic                  blank,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic {IDLE, CONV} state_t;

   state_t          state_reg, state_next;
   logic [WIDTH-1:0] bin_reg, bin_next;
   logic [BW-1:0]   work_reg, work_next;
   logic            ovf_work_reg, ovf_work_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [BW-1:0]   bcd_reg, bcd_next;
   logic            overflow_reg, overflow_next;
   logic            done_reg, done_next;

   logic [BW-1:0]   adj;
   logic [BW-1:0]   shift_work;
   logic            shift_ovf;

   // Add-3 correction on every working digit before the shift
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                 work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
      end
   endgenerate

   // A one leaving the top digit means the value no longer fits in DIGITS digits
   assign shift_work = {adj[BW-2:0], bin_reg[WIDTH-1]};
   assign shift_ovf  = ovf_work_reg | adj[BW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         bin_reg      <= '0;
         work_reg     <= '0;
         ovf_work_reg <= 1'b0;
         cnt_reg      <= '0;
         bcd_reg      <= '0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bin_reg      <= bin_next;
         work_reg     <= work_next;
         ovf_work_reg <= ovf_work_next;
         cnt_reg      <= cnt_next;
         bcd_reg      <= bcd_next;
         overflow_reg <= overflow_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bin_next      = bin_reg;
      work_next     = work_reg;
      ovf_work_next = ovf_work_reg;
      cnt_next      = cnt_reg;
      bcd_next      = bcd_reg;
      overflow_next = overflow_reg;
      done_next     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load) begin
               bin_next      = value;
               work_next     = '0;
               ovf_work_next = 1'b0;
               cnt_next      = '0;
               state_next    = CONV;
            end
         end
         CONV: begin
            work_next     = shift_work;
            bin_next      = bin_reg << 1;
            ovf_work_next = shift_ovf;
            cnt_next      = cnt_reg + CW'(1);
            if (cnt_reg == CW'(WIDTH - 1)) begin
               bcd_next      = shift_work;
               overflow_next = shift_ovf;
               done_next     = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    seg_pattern = 7'h3F;
         4'd1:    seg_pattern = 7'h06;
         4'd2:    seg_pattern = 7'h5B;
         4'd3:    seg_pattern = 7'h4F;
         4'd4:    seg_pattern = 7'h66;
         4'd5:    seg_pattern = 7'h6D;
         4'd6:    seg_pattern = 7'h7D;
         4'd7:    seg_pattern = 7'h07;
         4'd8:    seg_pattern = 7'h7F;
         4'd9:    seg_pattern = 7'h6F;
         default: seg_pattern = 7'h00;
      endcase
   endfunction

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
         localparam bit CAN_BLANK = (LZ_BLANK != 0) && (gi != 0);
         logic       nz_up;
         logic [6:0] lit;
         // Display is a leading zero when it and every digit above it are zero
         assign nz_up = |bcd_reg[BW-1:4*gi];
         always_comb begin
            lit = seg_pattern(bcd_reg[4*gi +: 4]);
            if (blank)
               lit = 7'h00;
            else if (overflow_reg)
               lit = 7'h40;
            else if (CAN_BLANK && !nz_up)
               lit = 7'h00;
         end
         assign seg[7*gi +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
      end
   endgenerate

   assign busy     = (state_reg == CONV);
   assign done     = done_reg;
   assign overflow = overflow_reg;
   assign bcd      = bcd_reg;
endmodule

// File: tb/tb_seg7_decimal_display.sv
// Directed bench for seg7_decimal_display: vector table of conversions plus
// handshake, blanking and mid-conversion reset sequences.
module tb_seg7_decimal_display;
   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic        blank;
   logic        busy, done, overflow;
   logic [15:0] bcd;
   logic [27:0] seg;
   logic        busy0, done0, overflow0;
   logic [15:0] bcd0;
   logic [27:0] seg0;

   int compared;
   int mismatched;

   seg7_decimal_display #(.WIDTH(16), .DIGITS(4), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank(blank),
      .busy(busy), .done(done), .overflow(overflow), .bcd(bcd), .seg(seg)
   );

   seg7_decimal_display #(.WIDTH(16), .DIGITS(4), .ACTIVE_LOW(1), .LZ_BLANK(0)) dut_nolz (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank(blank),
      .busy(busy0), .done(done0), .overflow(overflow0), .bcd(bcd0), .seg(seg0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic [15:0] exp_bcd;
      logic        exp_ovf;
      logic [27:0] exp_seg;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Loads v for one cycle and returns the number of edges from acceptance to done
   task automatic do_conv(input logic [15:0] v, output int lat);
      @(negedge clk);
      value = v;
      load  = 1'b1;
      @(posedge clk);
      #1;
      check("busy_after_load", {31'd0, busy}, 32'd1);
      @(negedge clk);
      load = 1'b0;
      lat  = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int  lat;
      bit  saw_done;
      compared   = 0;
      mismatched = 0;

      vecs[0] = '{16'd1234,  16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[1] = '{16'd9999,  16'h9999, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}};
      vecs[2] = '{16'd10000, 16'h0000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
      vecs[3] = '{16'd65535, 16'h5535, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
      vecs[4] = '{16'd7,     16'h0007, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
      vecs[5] = '{16'd0,     16'h0000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[6] = '{16'd905,   16'h0905, 1'b0, {7'h7F, 7'h10, 7'h40, 7'h12}};
      vecs[7] = '{16'd1,     16'h0001, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h79}};
      vecs[8] = '{16'd8642,  16'h8642, 1'b0, {7'h00, 7'h02, 7'h19, 7'h24}};
      vecs[9] = '{16'd10,    16'h0010, 1'b0, {7'h7F, 7'h7F, 7'h79, 7'h40}};

      rst_n = 1'b0;
      load  = 1'b0;
      value = '0;
      blank = 1'b0;
      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_ovf", {31'd0, overflow}, 32'd0);
      check("reset_bcd", {16'd0, bcd}, 32'h0);
      check("reset_seg_lz", {4'd0, seg}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      check("reset_seg_nolz", {4'd0, seg0}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_conv(vecs[i].value, lat);
         check($sformatf("v%0d_latency", vecs[i].value), lat, 32'd16);
         check($sformatf("v%0d_bcd", vecs[i].value), {16'd0, bcd}, {16'd0, vecs[i].exp_bcd});
         check($sformatf("v%0d_ovf", vecs[i].value), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
         check($sformatf("v%0d_seg", vecs[i].value), {4'd0, seg}, {4'd0, vecs[i].exp_seg});
         if (vecs[i].value == 16'd7)
            check("v7_seg_nolz", {4'd0, seg0}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h78});
      end

      // Load during conversion is ignored; result holds until done
      @(negedge clk);
      value = 16'd1234;
      load  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      value = 16'd4321;
      load  = 1'b1;
      #1;
      check("ignore_busy", {31'd0, busy}, 32'd1);
      check("hold_bcd", {16'd0, bcd}, 32'h0010);
      @(posedge clk);
      lat = 6;
      @(negedge clk);
      load = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("ignore_latency", lat, 32'd16);
      check("ignore_bcd", {16'd0, bcd}, 32'h1234);

      // Load in the done cycle is accepted
      check("b2b_done_cycle", {31'd0, done}, 32'd1);
      do_conv(16'd9999, lat);
      check("b2b_latency", lat, 32'd16);
      check("b2b_bcd", {16'd0, bcd}, 32'h9999);

      // Blank forces all segments off with no latency
      @(negedge clk);
      blank = 1'b1;
      #1;
      check("blank_seg", {4'd0, seg}, 32'h0FFFFFFF);
      check("blank_seg_nolz", {4'd0, seg0}, 32'h0FFFFFFF);
      blank = 1'b0;
      #1;
      check("unblank_seg", {4'd0, seg}, {4'd0, 7'h10, 7'h10, 7'h10, 7'h10});

      // Reset in the middle of a conversion
      @(negedge clk);
      value = 16'd4321;
      load  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_bcd", {16'd0, bcd}, 32'h0);
      check("midrst_seg", {4'd0, seg}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done || busy) saw_done = 1'b1;
      end
      check("midrst_no_done", {31'd0, saw_done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
